// File: rtl/swsc_frame_ctrl.sv
// Frame sequencer feeding the swsc convolution core: size latch, row/frame framing, output counting.
// Define SWSC_FRAME_CTRL_TIMEOUT_EN to add a drain watchdog that aborts a stuck frame with o_err.
module swsc_frame_ctrl #(
  parameter int DATA_W      = 8,
  parameter int KERNEL_H    = 7,
  parameter int MAX_IMG_W   = 640,
  parameter int MAX_IMG_H   = 480,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [$clog2(MAX_IMG_W+1)-1:0]   i_cfg_w,
  input  logic [$clog2(MAX_IMG_H+1)-1:0]   i_cfg_h,
  input  logic                             i_src_vld,
  input  logic [DATA_W-1:0]                i_src_data,
  output logic                             o_src_rdy,
  input  logic                             i_rdy,
  output logic                             o_vld,
  output logic                             o_eor,
  output logic                             o_eof,
  output logic [DATA_W-1:0]                o_data,
  input  logic                             i_out_vld,
  input  logic                             i_out_rdy,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err
);

  localparam int CW  = $clog2(MAX_IMG_W+1);
  localparam int HW  = $clog2(MAX_IMG_H+1);
  localparam int OCW = $clog2(MAX_IMG_W*MAX_IMG_H+1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d, cfg_w_q;
  logic [HW-1:0]  row_q, row_d, cfg_h_q;
  logic [OCW-1:0] cnt_q, cnt_d, n_q, n_calc;
  logic           busy_q, done_q, done_d, err_q, err_d, load;
  logic           run, in_hs, out_hs, col_last, row_last, cfg_ok, wd_expire;

  // Forward path: pure pass-through while a frame is being fed, forced quiet otherwise.
  assign run       = (state_q == RUN);
  assign o_vld     = run && i_src_vld;
  assign o_src_rdy = run && i_rdy;
  assign o_data    = run ? i_src_data : '0;
  assign in_hs     = o_vld && i_rdy;
  assign out_hs    = (state_q != IDLE) && i_out_vld && i_out_rdy;

  assign col_last  = (col_q == cfg_w_q - CW'(1));
  assign row_last  = (row_q == cfg_h_q - HW'(1));
  assign o_eor     = o_vld && col_last;
  assign o_eof     = o_eor && row_last;

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

  assign cfg_ok = (i_cfg_w >= CW'(KERNEL_H)) && (i_cfg_w <= CW'(MAX_IMG_W)) &&
                  (i_cfg_h >= HW'(KERNEL_H)) && (i_cfg_h <= HW'(MAX_IMG_H));

  // Valid-window output count for a frame: (W-K+1)*(H-K+1).
  assign n_calc = OCW'(i_cfg_w - CW'(KERNEL_H - 1)) * OCW'(i_cfg_h - HW'(KERNEL_H - 1));

`ifdef SWSC_FRAME_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC+1);
  logic [WW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = '0;
    if (state_q == DRAIN && !out_hs) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign wd_expire = (state_q == DRAIN) && !out_hs && (wd_q == WW'(TIMEOUT_CYC - 1));
`else
  // Without the watchdog the limit has no effect.
  wire unused_timeout = (TIMEOUT_CYC != 0);
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (cfg_ok) begin
            load    = 1'b1;
            col_d   = '0;
            row_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_hs) cnt_d = cnt_q + 1'b1;
        if (in_hs) begin
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) cnt_d = cnt_q + 1'b1;
        if (cnt_d >= n_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Frame geometry is data: only meaningful after an accepted start, so no reset.
  always_ff @(posedge i_clk) begin
    if (load) begin
      cfg_w_q <= i_cfg_w;
      cfg_h_q <= i_cfg_h;
      n_q     <= n_calc;
    end
  end

endmodule

// File: tb/tb_swsc_frame_ctrl.sv
// Scoreboard bench for swsc_frame_ctrl: framing, handshakes, completion, rejection and reset abort.
module tb_swsc_frame_ctrl;

  localparam int DATA_W    = 8;
  localparam int KERNEL_H  = 7;
  localparam int MAX_IMG_W = 640;
  localparam int MAX_IMG_H = 480;
  localparam int CW        = $clog2(MAX_IMG_W+1);
  localparam int HW        = $clog2(MAX_IMG_H+1);

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [CW-1:0]     i_cfg_w = '0;
  logic [HW-1:0]     i_cfg_h = '0;
  logic              i_src_vld = 1'b0;
  logic [DATA_W-1:0] i_src_data = '0;
  logic              o_src_rdy;
  logic              i_rdy = 1'b0;
  logic              o_vld, o_eor, o_eof;
  logic [DATA_W-1:0] o_data;
  logic              i_out_vld = 1'b0;
  logic              i_out_rdy = 1'b0;
  logic              o_busy, o_done, o_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W+1:0] sb[$];

  always #5 i_clk = ~i_clk;

  swsc_frame_ctrl #(
    .DATA_W(DATA_W), .KERNEL_H(KERNEL_H), .MAX_IMG_W(MAX_IMG_W), .MAX_IMG_H(MAX_IMG_H)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cfg_w(i_cfg_w), .i_cfg_h(i_cfg_h),
    .i_src_vld(i_src_vld), .i_src_data(i_src_data), .o_src_rdy(o_src_rdy), .i_rdy(i_rdy),
    .o_vld(o_vld), .o_eor(o_eor), .o_eof(o_eof), .o_data(o_data),
    .i_out_vld(i_out_vld), .i_out_rdy(i_out_rdy),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h);
    i_start = 1'b1;
    i_cfg_w = CW'(w);
    i_cfg_h = HW'(h);
    next_cycle();
    i_start = 1'b0;
  endtask

  task automatic do_reject(input int w, input int h, input string tag);
    do_start(w, h);
    @(negedge i_clk);
    check({tag, "_err"}, o_err, 1);
    check({tag, "_busy"}, o_busy, 0);
    next_cycle();
    @(negedge i_clk);
    check({tag, "_err_clear"}, o_err, 0);
    check({tag, "_busy_idle"}, o_busy, 0);
    next_cycle();
  endtask

  // Feeds up to 'limit' accepted pixels; mode 1 randomises valid and toggles ready.
  task automatic run_frame(input int w, input int h, input int limit, input bit mode,
                           input bit hold_start, input bit out_on_eof);
    int acc = 0, mc = 0, mr = 0, budget = 0;
    logic v, r, eor_e, eof_e;
    logic [DATA_W-1:0] d;
    logic [DATA_W+1:0] e;
    sb.delete();
    while (acc < limit && budget < 4000) begin
      v = mode ? 1'($urandom_range(0, 1)) : 1'b1;
      r = mode ? (budget % 2 == 1) : 1'b1;
      d = DATA_W'($urandom);
      eor_e = v && (mc == w - 1);
      eof_e = eor_e && (mr == h - 1);
      i_src_vld  = v;
      i_rdy      = r;
      i_src_data = d;
      i_start    = hold_start;
      if (hold_start) begin
        i_cfg_w = CW'(KERNEL_H);
        i_cfg_h = HW'(KERNEL_H);
      end
      i_out_vld = out_on_eof && eof_e && r;
      i_out_rdy = 1'b1;
      if (v && r) sb.push_back({d, eor_e, eof_e});
      @(negedge i_clk);
      check("vld", o_vld, v);
      check("src_rdy", o_src_rdy, r);
      check("eor", o_eor, eor_e);
      check("eof", o_eof, eof_e);
      check("busy_run", o_busy, 1);
      check("err_run", o_err, 0);
      if (o_vld && i_rdy) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_data", o_data, e[DATA_W+1:2]);
          check("sb_eor", o_eor, e[1]);
          check("sb_eof", o_eof, e[0]);
        end
      end
      if (v && r) begin
        acc++;
        if (mc == w - 1) begin
          mc = 0;
          mr++;
        end else begin
          mc++;
        end
      end
      budget++;
      next_cycle();
    end
    check("frame_accepted", acc, limit);
    i_start    = 1'b0;
    i_out_vld  = 1'b0;
    i_src_vld  = 1'b1;
    i_rdy      = 1'b1;
    i_src_data = 8'hC3;
  endtask

  task automatic drain_cycle_checks();
    @(negedge i_clk);
    check("drain_vld", o_vld, 0);
    check("drain_src_rdy", o_src_rdy, 0);
    check("drain_data", o_data, 0);
    check("done_early", o_done, 0);
    check("busy_drain", o_busy, 1);
    next_cycle();
  endtask

  // Delivers n output handshakes in DRAIN, then expects one o_done pulse.
  task automatic drain(input int n, input bit gap);
    if (n == 0) begin
      i_out_vld = 1'b0;
      drain_cycle_checks();
    end
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        i_out_vld = 1'b1;
        i_out_rdy = 1'b0;
        drain_cycle_checks();
      end
      i_out_vld = 1'b1;
      i_out_rdy = 1'b1;
      drain_cycle_checks();
    end
    i_out_vld = 1'b0;
    @(negedge i_clk);
    check("done_pulse", o_done, 1);
    check("busy_after", o_busy, 0);
    check("err_at_done", o_err, 0);
    next_cycle();
    @(negedge i_clk);
    check("done_once", o_done, 0);
    next_cycle();
    i_src_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    i_src_vld  = 1'b1;
    i_rdy      = 1'b1;
    i_src_data = 8'hA5;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_vld", o_vld, 0);
    check("rst_src_rdy", o_src_rdy, 0);
    check("rst_data", o_data, 0);
    check("rst_eor", o_eor, 0);
    check("rst_eof", o_eof, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    next_cycle();
    i_rst = 1'b0;

    // Output handshakes while idle must not count toward the next frame.
    i_out_vld = 1'b1;
    i_out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("idle_busy", o_busy, 0);
      check("idle_vld", o_vld, 0);
      check("idle_done", o_done, 0);
      next_cycle();
    end
    i_out_vld = 1'b0;

    // 8x8, full throughput, one output on the eof cycle, three more in drain.
    do_start(8, 8);
    run_frame(8, 8, 64, 1'b0, 1'b0, 1'b1);
    drain(3, 1'b0);

    // 10x7 with stalls and start held high (must not re-latch 7x7).
    do_start(10, 7);
    run_frame(10, 7, 70, 1'b1, 1'b1, 1'b0);
    drain(4, 1'b1);

    // Rejected configurations.
    do_reject(6, 8, "w_small");
    do_reject(641, 8, "w_big");
    do_reject(8, 6, "h_small");
    do_reject(8, 481, "h_big");

    // Asynchronous reset at pixel 30 aborts the frame.
    do_start(8, 8);
    run_frame(8, 8, 30, 1'b0, 1'b0, 1'b0);
    i_src_vld  = 1'b1;
    i_rdy      = 1'b1;
    i_src_data = 8'h5A;
    #1;
    i_rst = 1'b1;
    #1;
    check("arst_vld", o_vld, 0);
    check("arst_src_rdy", o_src_rdy, 0);
    check("arst_data", o_data, 0);
    check("arst_eor", o_eor, 0);
    check("arst_busy", o_busy, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      check("arst_done", o_done, 0);
      check("arst_err", o_err, 0);
      next_cycle();
    end
    i_rst = 1'b0;
    next_cycle();
    do_start(8, 8);
    run_frame(8, 8, 64, 1'b0, 1'b0, 1'b0);
    drain(4, 1'b0);

    // 7x7: the single output arrives with eof, done follows one DRAIN cycle later.
    do_start(7, 7);
    run_frame(7, 7, 49, 1'b0, 1'b0, 1'b1);
    drain(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
